// File: rtl/cache_pkg.sv
// Shared cache-side constants and types used by the memory responder.
package cache_pkg;

    localparam int LINE_BITS   = 128;
    localparam int ADDR_BITS   = 32;
    localparam int WORD_BITS   = 32;
    localparam int BEATS       = LINE_BITS / WORD_BITS;
    localparam int BEAT_BITS   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WB_BEAT   = 2'd1,
        FILL_BEAT = 2'd2,
        FILL_RESP = 2'd3
    } RespState_t;

    // Tag+index portion of a byte address; the offset is implied zero.
    typedef logic [ADDR_BITS-OFFSET_BITS-1:0] LineAddr_t;

    function automatic logic [ADDR_BITS-1:0] line_base(input logic [ADDR_BITS-1:0] addr);
        LineAddr_t la;
        la = addr[ADDR_BITS-1:OFFSET_BITS];
        return {la, {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_mem_responder_line_beat_buf.sv
// Line-wide register with full-line load, beat-indexed word write and word read mux.
module line_beat_buf #(
    parameter int LINE_BITS = 128,
    parameter int WORD_BITS = 32,
    parameter int BEAT_BITS = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [LINE_BITS-1:0] load_line_i,
    input  logic                 wr_i,
    input  logic [BEAT_BITS-1:0] wr_idx_i,
    input  logic [WORD_BITS-1:0] wr_word_i,
    input  logic [BEAT_BITS-1:0] rd_idx_i,
    output logic [WORD_BITS-1:0] rd_word_o,
    output logic [LINE_BITS-1:0] line_o
);

    localparam int NWORDS = LINE_BITS / WORD_BITS;

    logic [NWORDS-1:0][WORD_BITS-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = load_line_i;
        end else if (wr_i) begin
            line_d[wr_idx_i] = wr_word_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign rd_word_o = line_q[rd_idx_i];
    assign line_o    = line_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: serialises cache write-backs and fills into word beats.
// Optional write-back bypass for fills is enabled by defining CACHE_MEM_RESP_WB_BYPASS_EN.
module cache_mem_responder #(
    parameter int LINE_BITS = cache_pkg::LINE_BITS,
    parameter int ADDR_BITS = cache_pkg::ADDR_BITS,
    parameter int WORD_BITS = cache_pkg::WORD_BITS
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [ADDR_BITS-1:0] WrBackAddr,
    input  logic [LINE_BITS-1:0] WrBackData,
    input  logic                 WrBackAddrVal,
    output logic                 WrBackAddrRdy,
    input  logic [ADDR_BITS-1:0] FillAddr,
    input  logic                 FillReq,
    output logic                 FillRdy,
    output logic [LINE_BITS-1:0] FillData,
    output logic                 RdFillEn,
    input  logic                 WrDataRdy,
    output logic                 MemReq,
    output logic                 MemWrEn,
    output logic [ADDR_BITS-1:0] MemAddr,
    output logic [WORD_BITS-1:0] MemWrData,
    input  logic                 MemAck,
    input  logic [WORD_BITS-1:0] MemRdData
);

    import cache_pkg::*;

    localparam int NBEATS     = LINE_BITS / WORD_BITS;
    localparam int NB_W       = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int OFF_BITS   = $clog2(LINE_BITS / 8);
    localparam int WORD_BYTES = WORD_BITS / 8;
    localparam logic [NB_W-1:0] LAST_BEAT = NB_W'(NBEATS - 1);

    RespState_t             state_q, state_d;
    logic [NB_W-1:0]        beat_q, beat_d;
    logic [ADDR_BITS-1:0]   base_q, base_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_BITS-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic                   rd_fill_en_q, rd_fill_en_d;
    logic                   wb_rdy_q, wb_rdy_d;
    logic                   fill_rdy_q, fill_rdy_d;

    logic                   buf_load;
    logic [LINE_BITS-1:0]   buf_load_line;
    logic                   buf_wr;
    logic [WORD_BITS-1:0]   buf_rd_word;
    logic [LINE_BITS-1:0]   buf_line;

    logic [ADDR_BITS-1:0]   wb_base, fill_base, next_beat_addr;
    logic [NB_W-1:0]        beat_nxt;
    logic                   wb_acc, fill_acc;
    logic                   byp_hit;
    logic [LINE_BITS-1:0]   byp_line;

    assign wb_base   = {WrBackAddr[ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
    assign fill_base = {FillAddr[ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
    assign beat_nxt  = beat_q + NB_W'(1);
    assign next_beat_addr = base_q + ADDR_BITS'(beat_nxt) * ADDR_BITS'(WORD_BYTES);

    // A simultaneous write-back masks fill readiness so the fill is never accepted alongside it.
    assign wb_acc   = (state_q == IDLE) && wb_rdy_q && WrBackAddrVal;
    assign fill_acc = (state_q == IDLE) && fill_rdy_q && FillReq && !WrBackAddrVal;

`ifdef CACHE_MEM_RESP_WB_BYPASS_EN
    logic                 byp_vld_q;
    logic [ADDR_BITS-1:0] byp_addr_q;
    logic [LINE_BITS-1:0] byp_data_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            byp_vld_q  <= 1'b0;
            byp_addr_q <= '0;
            byp_data_q <= '0;
        end else if (wb_acc) begin
            byp_vld_q  <= 1'b1;
            byp_addr_q <= wb_base;
            byp_data_q <= WrBackData;
        end
    end

    assign byp_hit  = byp_vld_q && (byp_addr_q == fill_base);
    assign byp_line = byp_data_q;
`else
    assign byp_hit  = 1'b0;
    assign byp_line = '0;
`endif

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        base_d        = base_q;
        mem_req_d     = mem_req_q;
        mem_wr_en_d   = mem_wr_en_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        rd_fill_en_d  = rd_fill_en_q;
        wb_rdy_d      = wb_rdy_q;
        fill_rdy_d    = fill_rdy_q;
        buf_load      = 1'b0;
        buf_load_line = WrBackData;
        buf_wr        = 1'b0;

        unique case (state_q)
            IDLE: begin
                wb_rdy_d   = 1'b1;
                fill_rdy_d = 1'b1;
                if (wb_acc) begin
                    base_d        = wb_base;
                    beat_d        = '0;
                    buf_load      = 1'b1;
                    mem_req_d     = 1'b1;
                    mem_wr_en_d   = 1'b1;
                    mem_addr_d    = wb_base;
                    mem_wr_data_d = WrBackData[WORD_BITS-1:0];
                    wb_rdy_d      = 1'b0;
                    fill_rdy_d    = 1'b0;
                    state_d       = WB_BEAT;
                end else if (fill_acc) begin
                    base_d     = fill_base;
                    beat_d     = '0;
                    wb_rdy_d   = 1'b0;
                    fill_rdy_d = 1'b0;
                    if (byp_hit) begin
                        buf_load      = 1'b1;
                        buf_load_line = byp_line;
                        rd_fill_en_d  = 1'b1;
                        state_d       = FILL_RESP;
                    end else begin
                        mem_req_d     = 1'b1;
                        mem_wr_en_d   = 1'b0;
                        mem_addr_d    = fill_base;
                        mem_wr_data_d = '0;
                        state_d       = FILL_BEAT;
                    end
                end
            end
            WB_BEAT: begin
                if (MemAck) begin
                    if (beat_q == LAST_BEAT) begin
                        mem_req_d   = 1'b0;
                        mem_wr_en_d = 1'b0;
                        beat_d      = '0;
                        wb_rdy_d    = 1'b1;
                        fill_rdy_d  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        beat_d        = beat_nxt;
                        mem_addr_d    = next_beat_addr;
                        mem_wr_data_d = buf_rd_word;
                    end
                end
            end
            FILL_BEAT: begin
                if (MemAck) begin
                    buf_wr = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        mem_req_d    = 1'b0;
                        beat_d       = '0;
                        rd_fill_en_d = 1'b1;
                        state_d      = FILL_RESP;
                    end else begin
                        beat_d     = beat_nxt;
                        mem_addr_d = next_beat_addr;
                    end
                end
            end
            FILL_RESP: begin
                if (WrDataRdy) begin
                    rd_fill_en_d = 1'b0;
                    wb_rdy_d     = 1'b1;
                    fill_rdy_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            base_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            rd_fill_en_q  <= 1'b0;
            wb_rdy_q      <= 1'b0;
            fill_rdy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            base_q        <= base_d;
            mem_req_q     <= mem_req_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            rd_fill_en_q  <= rd_fill_en_d;
            wb_rdy_q      <= wb_rdy_d;
            fill_rdy_q    <= fill_rdy_d;
        end
    end

    line_beat_buf #(
        .LINE_BITS (LINE_BITS),
        .WORD_BITS (WORD_BITS),
        .BEAT_BITS (NB_W)
    ) u_line_buf (
        .clk_i       (Clk),
        .rst_ni      (Rst),
        .load_i      (buf_load),
        .load_line_i (buf_load_line),
        .wr_i        (buf_wr),
        .wr_idx_i    (beat_q),
        .wr_word_i   (MemRdData),
        .rd_idx_i    (beat_nxt),
        .rd_word_o   (buf_rd_word),
        .line_o      (buf_line)
    );

    assign WrBackAddrRdy = wb_rdy_q;
    assign FillRdy       = fill_rdy_q && !WrBackAddrVal;
    assign FillData      = buf_line;
    assign RdFillEn      = rd_fill_en_q;
    assign MemReq        = mem_req_q;
    assign MemWrEn       = mem_wr_en_q;
    assign MemAddr       = mem_addr_q;
    assign MemWrData     = mem_wr_data_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder; bypass expectations follow CACHE_MEM_RESP_WB_BYPASS_EN.
module tb_cache_mem_responder;

    import cache_pkg::*;

    localparam logic [31:0] OFF_MASK = 32'(LINE_BITS / 8 - 1);
    localparam int          WBYTES   = WORD_BITS / 8;

    logic                 Clk = 1'b0;
    logic                 Rst;
    logic [ADDR_BITS-1:0] WrBackAddr;
    logic [LINE_BITS-1:0] WrBackData;
    logic                 WrBackAddrVal;
    logic                 WrBackAddrRdy;
    logic [ADDR_BITS-1:0] FillAddr;
    logic                 FillReq;
    logic                 FillRdy;
    logic [LINE_BITS-1:0] FillData;
    logic                 RdFillEn;
    logic                 WrDataRdy;
    logic                 MemReq;
    logic                 MemWrEn;
    logic [ADDR_BITS-1:0] MemAddr;
    logic [WORD_BITS-1:0] MemWrData;
    logic                 MemAck;
    logic [WORD_BITS-1:0] MemRdData;

    cache_mem_responder dut (
        .Clk(Clk), .Rst(Rst),
        .WrBackAddr(WrBackAddr), .WrBackData(WrBackData),
        .WrBackAddrVal(WrBackAddrVal), .WrBackAddrRdy(WrBackAddrRdy),
        .FillAddr(FillAddr), .FillReq(FillReq), .FillRdy(FillRdy),
        .FillData(FillData), .RdFillEn(RdFillEn), .WrDataRdy(WrDataRdy),
        .MemReq(MemReq), .MemWrEn(MemWrEn), .MemAddr(MemAddr),
        .MemWrData(MemWrData), .MemAck(MemAck), .MemRdData(MemRdData)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } beat_t;

    int                   checks = 0;
    int                   errors = 0;
    beat_t                exp_beats[$];
    logic [LINE_BITS-1:0] exp_fill[$];
    logic [31:0]          ref_mem[logic [31:0]];
    logic [31:0]          slave_mem[logic [31:0]];
    logic                 byp_valid = 1'b0;
    logic [31:0]          byp_addr = '0;
    logic [LINE_BITS-1:0] byp_data = '0;
    int                   ack_mode = 0;
    int                   sink_mode = 0;
    logic                 sink_val = 1'b0;
    logic                 ack_tog = 1'b0;
    logic [31:0]          pool[5];

    task automatic chk(input string name, input logic [LINE_BITS-1:0] act, input logic [LINE_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
    endfunction

    // Reference model: a line is BEATS consecutive words, least-significant word first.
    task automatic model_wb(input logic [31:0] a, input logic [LINE_BITS-1:0] d);
        logic [31:0] base;
        beat_t       b;
        base = a & ~OFF_MASK;
        for (int i = 0; i < BEATS; i++) begin
            b.addr = base + 32'(i * WBYTES);
            b.wr   = 1'b1;
            b.data = d[i*WORD_BITS +: WORD_BITS];
            exp_beats.push_back(b);
            ref_mem[b.addr] = b.data;
        end
`ifdef CACHE_MEM_RESP_WB_BYPASS_EN
        byp_valid = 1'b1;
        byp_addr  = base;
        byp_data  = d;
`endif
    endtask

    task automatic model_fill(input logic [31:0] a);
        logic [31:0]          base;
        logic [LINE_BITS-1:0] line;
        beat_t                b;
        base = a & ~OFF_MASK;
        if (byp_valid && byp_addr == base) begin
            exp_fill.push_back(byp_data);
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                b.addr = base + 32'(i * WBYTES);
                b.wr   = 1'b0;
                b.data = '0;
                exp_beats.push_back(b);
                line[i*WORD_BITS +: WORD_BITS] = ref_rd(b.addr);
            end
            exp_fill.push_back(line);
        end
    endtask

    // Memory slave
    initial begin
        MemAck    = 1'b0;
        MemRdData = '0;
        forever begin
            @(posedge Clk);
            #1;
            case (ack_mode)
                0: MemAck = 1'b1;
                1: begin ack_tog = ~ack_tog; MemAck = ack_tog; end
                default: MemAck = ($urandom_range(0, 2) != 0);
            endcase
            MemRdData = slv_rd(MemAddr);
        end
    end

    initial forever begin
        @(negedge Clk);
        if (Rst && MemReq && MemAck && MemWrEn) slave_mem[MemAddr] = MemWrData;
    end

    // Fill-data sink
    initial begin
        WrDataRdy = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            case (sink_mode)
                0: WrDataRdy = 1'b1;
                1: WrDataRdy = 1'($urandom_range(0, 1));
                default: WrDataRdy = sink_val;
            endcase
        end
    end

    // Monitor
    initial forever begin
        beat_t b;
        @(negedge Clk);
        if (Rst) begin
            if (MemReq && MemAck) begin
                if (exp_beats.size() == 0) begin
                    fail_note("unexpected_mem_beat");
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat_addr", MemAddr, b.addr);
                    chk("beat_wren", MemWrEn, b.wr);
                    if (b.wr) chk("beat_wdata", MemWrData, b.data);
                end
            end
            if (RdFillEn) begin
                chk("fill_no_memreq", MemReq, 1'b0);
                if (exp_fill.size() == 0) begin
                    fail_note("unexpected_fill");
                end else begin
                    chk("fill_data", FillData, exp_fill[0]);
                    if (WrDataRdy) void'(exp_fill.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while (!(WrBackAddrRdy && FillRdy && exp_fill.size() == 0) && n < 400) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 400) fail_note("wait_idle");
        @(posedge Clk);
        #1;
    endtask

    task automatic do_wb(input logic [31:0] a, input logic [LINE_BITS-1:0] d);
        int n = 0;
        WrBackAddr = a; WrBackData = d; WrBackAddrVal = 1'b1;
        @(negedge Clk);
        while (!WrBackAddrRdy && n < 400) begin @(negedge Clk); n++; end
        if (WrBackAddrRdy) model_wb(a, d);
        else fail_note("wb_accept");
        @(posedge Clk);
        #1;
        WrBackAddrVal = 1'b0;
        WrBackData    = {$urandom, $urandom, $urandom, $urandom};
        WrBackAddr    = $urandom;
    endtask

    task automatic do_fill(input logic [31:0] a);
        int n = 0;
        FillAddr = a; FillReq = 1'b1;
        @(negedge Clk);
        while (!FillRdy && n < 400) begin @(negedge Clk); n++; end
        if (FillRdy) model_fill(a);
        else fail_note("fill_accept");
        @(posedge Clk);
        #1;
        FillReq  = 1'b0;
        FillAddr = $urandom;
    endtask

    task automatic do_both(input logic [31:0] wa, input logic [LINE_BITS-1:0] wd, input logic [31:0] fa);
        int n = 0;
        WrBackAddr = wa; WrBackData = wd; WrBackAddrVal = 1'b1;
        FillAddr = fa; FillReq = 1'b1;
        @(negedge Clk);
        while (!WrBackAddrRdy && n < 400) begin @(negedge Clk); n++; end
        if (WrBackAddrRdy) begin
            chk("both_fillrdy_masked", FillRdy, 1'b0);
            model_wb(wa, wd);
        end else begin
            fail_note("both_wb_accept");
        end
        @(posedge Clk);
        #1;
        WrBackAddrVal = 1'b0;
        n = 0;
        @(negedge Clk);
        while (!FillRdy && n < 400) begin @(negedge Clk); n++; end
        if (FillRdy) begin
            chk("both_wb_beats_done_first", 32'(exp_beats.size()), 32'd0);
            model_fill(fa);
        end else begin
            fail_note("both_fill_accept");
        end
        @(posedge Clk);
        #1;
        FillReq = 1'b0;
    endtask

    task automatic wait_rdfill(input string name);
        int n = 0;
        while (!RdFillEn && n < 400) begin @(posedge Clk); #1; n++; end
        if (!RdFillEn) fail_note(name);
    endtask

    initial begin
        Rst = 1'b1;
        WrBackAddr = '0; WrBackData = '0; WrBackAddrVal = 1'b0;
        FillAddr = '0; FillReq = 1'b0;
        pool[0] = 32'h0000_1000; pool[1] = 32'h0000_1010; pool[2] = 32'h0000_2040;
        pool[3] = 32'h0000_7000; pool[4] = 32'h8000_0FF0;
        #2 Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_wbrdy", WrBackAddrRdy, 1'b0);
        chk("rst_memreq", MemReq, 1'b0);
        chk("rst_rdfill", RdFillEn, 1'b0);
        #2 Rst = 1'b1;
        @(posedge Clk);
        #1;
        // Test 1: first cycle after release
        chk("idle_wbrdy", WrBackAddrRdy, 1'b1);
        chk("idle_fillrdy", FillRdy, 1'b1);
        chk("idle_memreq", MemReq, 1'b0);
        chk("idle_memwren", MemWrEn, 1'b0);
        chk("idle_memaddr", MemAddr, 32'h0);
        chk("idle_memwdata", MemWrData, 32'h0);
        chk("idle_rdfill", RdFillEn, 1'b0);
        chk("idle_filldata", FillData, '0);

        // Test 2: write-back, MemAck always high
        ack_mode = 0; sink_mode = 0;
        do_wb(32'h0000_1230, 128'h00000044_00000033_00000022_00000011);
        chk("wb_memreq_t1", MemReq, 1'b1);
        chk("wb_rdy_low_t1", WrBackAddrRdy, 1'b0);
        repeat (3) begin
            @(posedge Clk); #1;
            chk("wb_rdy_low", WrBackAddrRdy, 1'b0);
        end
        @(posedge Clk); #1;
        chk("wb_rdy_t5", WrBackAddrRdy, 1'b1);
        chk("wb_fillrdy_t5", FillRdy, 1'b1);
        chk("wb_memreq_t5", MemReq, 1'b0);

        // Zero-wait fill latency
        wait_idle();
        do_fill(32'h0000_6004);
        repeat (3) begin @(posedge Clk); #1; end
        chk("fill_lat_t4", RdFillEn, 1'b0);
        @(posedge Clk); #1;
        chk("fill_lat_t5", RdFillEn, 1'b1);

        // Test 3: fill with MemAck every second cycle
        wait_idle();
        for (int i = 0; i < BEATS; i++) begin
            slave_mem[32'h2000 + 32'(4 * i)] = 32'hA + 32'(i);
            ref_mem[32'h2000 + 32'(4 * i)]   = 32'hA + 32'(i);
        end
        ack_mode = 1;
        do_fill(32'h0000_2000);
        wait_rdfill("fill_abcd_rdfill");
        chk("fill_abcd", FillData, 128'h0000000D_0000000C_0000000B_0000000A);

        // Test 4: fill held while the cache is not ready
        wait_idle();
        ack_mode = 2; sink_mode = 2; sink_val = 1'b0;
        do_fill(32'h0000_4008);
        wait_rdfill("hold_rdfill");
        repeat (3) begin
            @(posedge Clk); #1;
            chk("hold_rdfill_high", RdFillEn, 1'b1);
        end
        @(negedge Clk);
        sink_val = 1'b1;
        @(posedge Clk); #1;
        chk("hold_rdfill_taken", RdFillEn, 1'b1);
        @(posedge Clk); #1;
        chk("hold_rdfill_drop", RdFillEn, 1'b0);
        sink_mode = 0;

        // Test 5: simultaneous write-back and fill
        wait_idle();
        do_both(32'h0000_3010, {$urandom, $urandom, $urandom, $urandom}, 32'h0000_3010);
        wait_idle();

        // Test 6: reset during beat 2 of a fill
        ack_mode = 0;
        do_fill(32'h0000_5000);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        exp_beats.delete();
        exp_fill.delete();
        byp_valid = 1'b0;
        #1;
        chk("rst_mid_memreq", MemReq, 1'b0);
        chk("rst_mid_rdfill", RdFillEn, 1'b0);
        chk("rst_mid_filldata", FillData, '0);
        repeat (2) @(posedge Clk);
        #3 Rst = 1'b1;
        @(posedge Clk); #1;
        chk("rst_rel_wbrdy", WrBackAddrRdy, 1'b1);
        chk("rst_rel_memreq", MemReq, 1'b0);
        do_fill(32'h0000_3010);
        wait_idle();

`ifdef CACHE_MEM_RESP_WB_BYPASS_EN
        do_wb(32'h0000_9000, 128'hDEAD0003_BEEF0002_CAFE0001_F00D0000);
        wait_idle();
        do_fill(32'h0000_900C);
        chk("byp_rdfill_t1", RdFillEn, 1'b1);
        chk("byp_memreq_t1", MemReq, 1'b0);
        chk("byp_data_t1", FillData, 128'hDEAD0003_BEEF0002_CAFE0001_F00D0000);
        wait_idle();
`endif

        // Randomised traffic
        ack_mode = 2; sink_mode = 1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0]          a;
            logic [LINE_BITS-1:0] d;
            int                   k;
            a = pool[$urandom_range(0, 4)] | 32'($urandom_range(0, 15));
            d = {$urandom, $urandom, $urandom, $urandom};
            k = $urandom_range(0, 4);
            if (k < 2) do_wb(a, d);
            else if (k < 4) do_fill(a);
            else do_both(a, d, pool[$urandom_range(0, 4)]);
        end
        ack_mode = 0; sink_mode = 0;
        wait_idle();
        chk("drain_beats", 32'(exp_beats.size()), 32'd0);
        chk("drain_fills", 32'(exp_fill.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
